// File: rtl/alu_seq_exec_if.sv
// alu_seq_exec_if: start/ready/done handshake plus operand and result bus
// between the core pipeline (master) and the sequential ALU (slave).
interface alu_seq_exec_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [3:0]            alu_operation_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  ready_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;
  logic                  branch_taken_o;
  logic                  illegal_op_o;

  modport master (
    output start_i, alu_operation_i, a_i, b_i,
    input  ready_o, done_o, result_o, zero_o, branch_taken_o, illegal_op_o
  );

  modport slave (
    input  start_i, alu_operation_i, a_i, b_i,
    output ready_o, done_o, result_o, zero_o, branch_taken_o, illegal_op_o
  );
endinterface

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: sequential ALU execution unit.
// Single-cycle ops complete the cycle after acceptance; SLL/SRL iterate one
// bit per cycle unless ALU_BARREL_SHIFT_EN is defined, in which case they use
// a combinational barrel shifter and the SHIFT state/counter are not built.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | ready for a new op; single-cycle ops complete from here
//   S_SHIFT | iterative shift in flight; result_q shifts 1 bit per cycle
module alu_seq_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic           clk,
  input  logic           reset,
  alu_seq_exec_if.slave  bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_LUI = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_BEQ = 4'b1001;
  localparam logic [3:0] OP_BNE = 4'b1010;
  localparam logic [3:0] OP_BLT = 4'b1011;
  localparam logic [3:0] OP_BGE = 4'b1100;
  localparam logic [3:0] OP_JAL = 4'b1101;

  localparam logic [DATA_WIDTH-1:0] LINK_OFS = DATA_WIDTH'(4);

  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  diff;
  logic                   lt_signed;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   alu_branch;
  logic                   alu_illegal;

  logic [DATA_WIDTH-1:0]  result_q;
  logic                   zero_q;
  logic                   branch_q;
  logic                   illegal_q;
  logic                   done_q;

  assign shamt     = bus.b_i[SHAMT_WIDTH-1:0];
  assign diff      = bus.a_i - bus.b_i;
  assign lt_signed = $signed(bus.a_i) < $signed(bus.b_i);

  // Combinational result/flags for an op completing at the accepting edge.
  always_comb begin
    alu_res     = '0;
    alu_branch  = 1'b0;
    alu_illegal = 1'b0;
    case (bus.alu_operation_i)
      OP_ADD: alu_res = bus.a_i + bus.b_i;
      OP_SUB: alu_res = diff;
      OP_AND: alu_res = bus.a_i & bus.b_i;
      OP_OR:  alu_res = bus.a_i | bus.b_i;
      OP_XOR: alu_res = bus.a_i ^ bus.b_i;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SRL: alu_res = bus.a_i >> shamt;
      OP_SLL: alu_res = bus.a_i << shamt;
`else
      // Only reached here with shamt == 0; nonzero amounts go to S_SHIFT.
      OP_SRL, OP_SLL: alu_res = bus.a_i;
`endif
      OP_LUI: alu_res = bus.b_i;
      OP_BEQ: begin alu_res = diff; alu_branch = (bus.a_i == bus.b_i); end
      OP_BNE: begin alu_res = diff; alu_branch = (bus.a_i != bus.b_i); end
      OP_BLT: begin alu_res = diff; alu_branch = lt_signed;            end
      OP_BGE: begin alu_res = diff; alu_branch = !lt_signed;           end
      OP_JAL: alu_res = bus.a_i + LINK_OFS;
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN

  // Every op completes the cycle after acceptance; the unit is always ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= bus.start_i;
      if (bus.start_i) begin
        result_q  <= alu_res;
        zero_q    <= (alu_res == '0);
        branch_q  <= alu_branch;
        illegal_q <= alu_illegal;
      end
    end
  end

  assign bus.ready_o = 1'b1;

`else

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   left_q, left_d;
  logic [DATA_WIDTH-1:0]  result_d;
  logic [DATA_WIDTH-1:0]  shifted;
  logic                   zero_d, branch_d, illegal_d, done_d;
  logic                   is_shift;

  assign is_shift = (bus.alu_operation_i == OP_SLL) ||
                    (bus.alu_operation_i == OP_SRL);
  assign shifted  = left_q ? (result_q << 1) : (result_q >> 1);

  // State, shift counter and registered outputs; reset aborts any shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  // Next-state: accept in IDLE, iterate the shift one bit per cycle in SHIFT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    result_d  = result_q;
    zero_d    = zero_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if (is_shift && (shamt != '0)) begin
            // Operands are captured here; later bus changes cannot disturb the shift.
            state_d  = S_SHIFT;
            result_d = bus.a_i;
            cnt_d    = shamt;
            left_d   = (bus.alu_operation_i == OP_SLL);
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            branch_d  = alu_branch;
            illegal_d = alu_illegal;
            done_d    = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        result_d = shifted;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d   = S_IDLE;
          zero_d    = (shifted == '0);
          branch_d  = 1'b0;
          illegal_d = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready_o = (state_q == S_IDLE);

`endif

  assign bus.done_o         = done_q;
  assign bus.result_o       = result_q;
  assign bus.zero_o         = zero_q;
  assign bus.branch_taken_o = branch_q;
  assign bus.illegal_op_o   = illegal_q;

endmodule
